// File: rtl/taho_pkg.sv
// Shared constants for the tacho/impulse front end: parameter defaults,
// channel indices and a counter-width helper.
package taho_pkg;

    localparam int CLK_PER_MSEC_DEF = 1000;
    localparam int MSEC_PER_SEC_DEF = 1000;
    localparam int FILT_LEN_DEF     = 8;
    localparam int STUCK_SEC_DEF    = 5;

    localparam int CH_TAHO1  = 0;
    localparam int CH_TAHO2  = 1;
    localparam int CH_IMPULS = 2;
    localparam int N_CH      = 3;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/taho_front_end_if.sv
// Field-side bundle of the front end: raw inputs in, timebase strobes,
// filtered levels and stuck flags out.
interface taho_front_end_if;
    import taho_pkg::*;

    logic            taho1_raw;
    logic            taho2_raw;
    logic            impuls_raw;
    logic            msec;
    logic            sec;
    logic            taho1;
    logic            taho2;
    logic            impuls;
    logic [N_CH-1:0] stuck;

    modport master (
        output taho1_raw, taho2_raw, impuls_raw,
        input  msec, sec, taho1, taho2, impuls, stuck
    );

    modport slave (
        input  taho1_raw, taho2_raw, impuls_raw,
        output msec, sec, taho1, taho2, impuls, stuck
    );

endinterface

// File: rtl/taho_in_filter.sv
// One input channel: two-flop synchroniser, stability filter and a
// seconds-based no-activity detector.
module taho_in_filter
    import taho_pkg::*;
#(
    parameter int FILT_LEN  = FILT_LEN_DEF,
    parameter int STUCK_SEC = STUCK_SEC_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic sec,
    input  logic raw,
    output logic filt,
    output logic stuck
);

    localparam int FCNT_W = cnt_w(FILT_LEN + 1);
    localparam int SCNT_W = cnt_w(STUCK_SEC + 1);

    logic              meta_q;
    logic              sync_q;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              filt_q, filt_d;
    logic              edge_q;
    logic              toggle;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              stuck_q, stuck_d;

    always_comb begin
        toggle = 1'b0;
        fcnt_d = '0;
        // The FILT_LEN-th consecutive differing sample flips the output.
        if (sync_q != filt_q) begin
            if (fcnt_q == FCNT_W'(FILT_LEN - 1)) begin
                toggle = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        filt_d = filt_q ^ toggle;

        // An edge outranks a coincident sec strobe.
        scnt_d = scnt_q;
        if (edge_q) begin
            scnt_d = '0;
        end else if (sec && (scnt_q != SCNT_W'(STUCK_SEC))) begin
            scnt_d = scnt_q + 1'b1;
        end
        stuck_d = (scnt_d == SCNT_W'(STUCK_SEC));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            fcnt_q  <= '0;
            filt_q  <= 1'b0;
            edge_q  <= 1'b0;
            scnt_q  <= '0;
            stuck_q <= 1'b0;
        end else begin
            meta_q  <= raw;
            sync_q  <= meta_q;
            fcnt_q  <= fcnt_d;
            filt_q  <= filt_d;
            edge_q  <= toggle;
            scnt_q  <= scnt_d;
            stuck_q <= stuck_d;
        end
    end

    assign filt  = filt_q;
    assign stuck = stuck_q;

endmodule

// File: rtl/taho_front_end.sv
// Conditioning stage ahead of the tacho/impulse counters: msec/sec timebase
// plus three identical filtered input channels.
module taho_front_end
    import taho_pkg::*;
#(
    parameter int CLK_PER_MSEC = CLK_PER_MSEC_DEF,
    parameter int MSEC_PER_SEC = MSEC_PER_SEC_DEF,
    parameter int FILT_LEN     = FILT_LEN_DEF,
    parameter int STUCK_SEC    = STUCK_SEC_DEF
) (
    input  logic            clock,
    input  logic            reset,
    taho_front_end_if.slave io
);

    localparam int PRE_W = cnt_w(CLK_PER_MSEC);
    localparam int MS_W  = cnt_w(MSEC_PER_SEC);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [MS_W-1:0]  msec_cnt_q, msec_cnt_d;
    logic             msec_tick;
    logic             sec_tick;
    logic [N_CH-1:0]  raw_vec;
    logic [N_CH-1:0]  filt_vec;
    logic [N_CH-1:0]  stuck_vec;

    // Strobes decode the counter state directly, so sec always rides on msec.
    assign msec_tick = (presc_q == PRE_W'(CLK_PER_MSEC - 1));
    assign sec_tick  = msec_tick && (msec_cnt_q == MS_W'(MSEC_PER_SEC - 1));

    always_comb begin
        presc_d    = msec_tick ? '0 : presc_q + 1'b1;
        msec_cnt_d = msec_cnt_q;
        if (sec_tick) begin
            msec_cnt_d = '0;
        end else if (msec_tick) begin
            msec_cnt_d = msec_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q    <= '0;
            msec_cnt_q <= '0;
        end else begin
            presc_q    <= presc_d;
            msec_cnt_q <= msec_cnt_d;
        end
    end

    assign raw_vec[CH_TAHO1]  = io.taho1_raw;
    assign raw_vec[CH_TAHO2]  = io.taho2_raw;
    assign raw_vec[CH_IMPULS] = io.impuls_raw;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            taho_in_filter #(
                .FILT_LEN  (FILT_LEN),
                .STUCK_SEC (STUCK_SEC)
            ) u_filt (
                .clock (clock),
                .reset (reset),
                .sec   (sec_tick),
                .raw   (raw_vec[gi]),
                .filt  (filt_vec[gi]),
                .stuck (stuck_vec[gi])
            );
        end
    endgenerate

    assign io.msec   = msec_tick;
    assign io.sec    = sec_tick;
    assign io.taho1  = filt_vec[CH_TAHO1];
    assign io.taho2  = filt_vec[CH_TAHO2];
    assign io.impuls = filt_vec[CH_IMPULS];
    assign io.stuck  = stuck_vec;

endmodule

// File: tb/tb_taho_front_end.sv
// Directed bench for taho_front_end with a small timebase (10 clk/msec,
// 5 msec/sec), FILT_LEN=8 and STUCK_SEC=3.
module tb_taho_front_end;

    logic clock;
    logic reset;
    int   err_cnt;
    int   chk_cnt;
    int   k;    // falling edges seen since the most recent reset release point

    taho_front_end_if fe_if ();

    taho_front_end #(
        .CLK_PER_MSEC (10),
        .MSEC_PER_SEC (5),
        .FILT_LEN     (8),
        .STUCK_SEC    (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io    (fe_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s @k=%0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        k++;
    endtask

    task automatic wait_to(input int n);
        while (k < n) step();
    endtask

    bit bounce_pat [12] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        k       = 0;
        reset   = 1'b1;
        fe_if.taho1_raw  = 1'b0;
        fe_if.taho2_raw  = 1'b0;
        fe_if.impuls_raw = 1'b0;

        repeat (3) @(negedge clock);
        check_eq("rst_msec",   fe_if.msec,   0);
        check_eq("rst_sec",    fe_if.sec,    0);
        check_eq("rst_taho1",  fe_if.taho1,  0);
        check_eq("rst_taho2",  fe_if.taho2,  0);
        check_eq("rst_impuls", fe_if.impuls, 0);
        check_eq("rst_stuck",  fe_if.stuck,  0);
        $display("reset state checked");
        reset = 1'b0;
        k     = 0;

        // Timebase: msec on every 10th edge, sec on every 50th edge.
        for (int c = 1; c <= 100; c++) begin
            wait_to(c);
            check_eq("tb_msec", fe_if.msec, 32'((c % 10) == 9));
            check_eq("tb_sec",  fe_if.sec,  32'((c % 50) == 49));
        end
        $display("timebase checked over 100 cycles");

        // Third sec at k=149 sets all stuck flags one cycle later.
        wait_to(149); check_eq("stuck_pre3", fe_if.stuck, 3'b000);
        wait_to(150); check_eq("stuck_set3", fe_if.stuck, 3'b111);
        $display("initial stuck detect checked");

        // Seven-sample glitch on taho1 is discarded.
        wait_to(160); fe_if.taho1_raw = 1'b1;
        wait_to(167); fe_if.taho1_raw = 1'b0;
        for (int c = 168; c <= 190; c++) begin
            wait_to(c);
            check_eq("glitch7_taho1", fe_if.taho1, 0);
        end
        $display("7-sample glitch checked");

        // Eight-sample pulse: rise at 210, fall at 218.
        wait_to(200); fe_if.taho1_raw = 1'b1;
        wait_to(208); fe_if.taho1_raw = 1'b0;
        wait_to(209); check_eq("p8_taho1_pre",  fe_if.taho1, 0);
        wait_to(210); check_eq("p8_taho1_rise", fe_if.taho1, 1);
                      check_eq("p8_stuck0_hold", fe_if.stuck[0], 1);
        wait_to(211); check_eq("p8_stuck0_clr", fe_if.stuck[0], 0);
        wait_to(217); check_eq("p8_taho1_hi",   fe_if.taho1, 1);
        wait_to(218); check_eq("p8_taho1_fall", fe_if.taho1, 0);
        $display("8-sample pulse checked");

        // Bounce on impuls: the 0 is sampled at edge 234, rise at 244.
        for (int i = 0; i < 12; i++) begin
            wait_to(230 + i);
            fe_if.impuls_raw = bounce_pat[i];
        end
        wait_to(243); check_eq("bnc_impuls_pre",  fe_if.impuls, 0);
        wait_to(244); check_eq("bnc_impuls_rise", fe_if.impuls, 1);
                      check_eq("bnc_taho1",       fe_if.taho1,  0);
                      check_eq("bnc_taho2",       fe_if.taho2,  0);
        wait_to(245); check_eq("bnc_stuck2_clr",  fe_if.stuck[2], 0);
        $display("bounce checked");

        // taho2 edge clears stuck[1]; it re-sets after secs at 299/349/399.
        wait_to(260); fe_if.taho2_raw = 1'b1;
        wait_to(269); check_eq("t2_taho2_pre",   fe_if.taho2, 0);
        wait_to(270); check_eq("t2_taho2_rise",  fe_if.taho2, 1);
                      check_eq("t2_stuck1_hold", fe_if.stuck[1], 1);
        wait_to(271); check_eq("t2_stuck1_clr",  fe_if.stuck[1], 0);
        $display("taho2 stuck clear checked");

        // taho1 filtered edge lands on the sec at 349 with its count at 2.
        wait_to(339); fe_if.taho1_raw = 1'b1;
        wait_to(348); check_eq("sim_taho1_pre",  fe_if.taho1, 0);
        wait_to(349); check_eq("sim_taho1_rise", fe_if.taho1, 1);
                      check_eq("sim_sec",        fe_if.sec,   1);
        wait_to(350); check_eq("sim_stuck0",     fe_if.stuck[0], 0);
                      check_eq("sim_stuck2_set", fe_if.stuck[2], 1);
        wait_to(399); check_eq("t2_stuck1_pre",  fe_if.stuck[1], 0);
        wait_to(400); check_eq("t2_stuck1_set",  fe_if.stuck[1], 1);
                      check_eq("sim_stuck0_400", fe_if.stuck[0], 0);
        wait_to(450); check_eq("sim_stuck0_450", fe_if.stuck[0], 0);
        wait_to(499); check_eq("sim_stuck0_499", fe_if.stuck[0], 0);
        wait_to(500); check_eq("sim_stuck0_500", fe_if.stuck[0], 1);
        $display("simultaneous edge/sec checked");

        // Reset mid-period with a partially counted taho1 pulse pending.
        fe_if.taho1_raw = 1'b0;
        wait_to(510); check_eq("pre_rst_taho1_fall", fe_if.taho1, 0);
        wait_to(520); fe_if.taho1_raw = 1'b1;
        wait_to(525); check_eq("pre_rst_stuck", fe_if.stuck, 3'b110);
        reset = 1'b1;
        wait_to(526);
        check_eq("mid_rst_msec",   fe_if.msec,   0);
        check_eq("mid_rst_sec",    fe_if.sec,    0);
        check_eq("mid_rst_taho1",  fe_if.taho1,  0);
        check_eq("mid_rst_taho2",  fe_if.taho2,  0);
        check_eq("mid_rst_impuls", fe_if.impuls, 0);
        check_eq("mid_rst_stuck",  fe_if.stuck,  0);
        reset = 1'b0;
        for (int c = 527; c <= 550; c++) begin
            wait_to(c);
            if (c == 532) fe_if.taho1_raw = 1'b0;
            if (c <= 536) check_eq("rr_msec", fe_if.msec, 32'(c == 535));
            if (c == 535) check_eq("rr_taho2_pre",  fe_if.taho2, 0);
            if (c == 536) check_eq("rr_taho2_rise", fe_if.taho2, 1);
            check_eq("rr_taho1_partial", fe_if.taho1, 0);
        end
        $display("mid-operation reset checked");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
